// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response channel bundle between load/store unit and data memory responder
interface data_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [2:0]            req_size;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    // Requester side (load/store unit)
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Responder side (memory)
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding data RAM responder with wait states and RISC-V load/store sizing
module data_mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_responder_if.slave bus
);
    localparam int                    IDX_W      = $clog2(MEM_WORDS);
    localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(MEM_WORDS * 4);
    localparam logic [3:0]            WS_LOAD    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  lat_write;
    logic [DATA_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [2:0]            lat_size;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic                  acc_write;
    logic [DATA_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [2:0]            acc_size;
    logic [IDX_W-1:0]      acc_idx;
    logic                  size_ok;
    logic                  align_ok;
    logic                  acc_err;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] acc_rdata;
    logic [3:0]            acc_be;
    logic [DATA_WIDTH-1:0] acc_wword;
    logic                  do_access;
    logic                  mem_we;

    // With zero wait states the access happens on the accept edge, so it must see the live request
    always_comb begin
        acc_write = lat_write;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_size  = lat_size;
        if (WAIT_STATES == 0) begin
            acc_write = bus.req_write;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_size  = bus.req_size;
        end
    end

    // Legality check, load lane extraction/extension and store lane steering
    always_comb begin
        acc_idx  = acc_addr[IDX_W+1:2];
        rd_word  = mem[acc_idx];
        size_ok  = 1'b1;
        align_ok = 1'b1;
        case (acc_size)
            3'b000, 3'b100: align_ok = 1'b1;
            3'b001, 3'b101: align_ok = ~acc_addr[0];
            3'b010:         align_ok = (acc_addr[1:0] == 2'b00);
            default: begin
                size_ok  = 1'b0;
                align_ok = 1'b0;
            end
        endcase
        // Unsigned sizes only make sense for loads
        if (acc_write && acc_size[2]) begin
            size_ok = 1'b0;
        end
        acc_err = !size_ok || !align_ok || (acc_addr >= ADDR_LIMIT);

        rd_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
        rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (acc_size)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
        acc_rdata = (acc_err || acc_write) ? '0 : load_val;

        case (acc_size[1:0])
            2'b00: begin
                acc_be    = 4'b0001 << acc_addr[1:0];
                acc_wword = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                acc_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
                acc_wword = {2{acc_wdata[15:0]}};
            end
            default: begin
                acc_be    = 4'b1111;
                acc_wword = acc_wdata;
            end
        endcase

        do_access = ((WAIT_STATES == 0) && (state == ST_IDLE) && bus.req_valid && bus.req_ready)
                 || ((state == ST_WAIT) && (cnt == 4'd1));
        // Reset at the access edge drops the pending store
        mem_we = rst && do_access && acc_write && !acc_err;
    end

    // Byte-lane write port; RAM contents survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && acc_be[i]) begin
                mem[acc_idx][8*i +: 8] <= acc_wword[8*i +: 8];
            end
        end
    end

    // Request/response FSM with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cnt           <= 4'd0;
            lat_write     <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            lat_size      <= 3'b000;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        lat_write     <= bus.req_write;
                        lat_addr      <= bus.req_addr;
                        lat_wdata     <= bus.req_wdata;
                        lat_size      <= bus.req_size;
                        cnt           <= WS_LOAD;
                        bus.req_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state         <= ST_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rdata <= acc_rdata;
                            bus.rsp_err   <= acc_err;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state         <= ST_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= acc_rdata;
                        bus.rsp_err   <= acc_err;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= ST_IDLE;
                        bus.req_ready <= 1'b1;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.req_ready <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
